// File: rtl/latrsnq_wr_ctrl_pkg.sv
// Shared types and defaults for the latch write controller: op encoding,
// FSM states, default phase lengths and the phase-counter load helper.
package latrsnq_wr_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_PRESET = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        ASYNC,
        RECOV,
        CHECK
    } state_e;

    localparam int SETUP_CYC_DEF = 2;
    localparam int WIDTH_CYC_DEF = 3;
    localparam int HOLD_CYC_DEF  = 1;
    localparam int RECOV_CYC_DEF = 2;
    localparam int CHECK_CYC     = 3;

    // Phase counters count down from N-1 and advance when they hit zero.
    function automatic logic [3:0] phase_load(input int n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/latrsnq_wr_ctrl_sync.sv
// Two-flop synchronizer bringing the latch's Q into the CLK domain.
module latrsnq_wr_ctrl_sync (
    input  logic CLK,
    input  logic RN,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/latrsnq_wr_ctrl.sv
// Sequencer for a D latch with async clear/preset: times the E pulse and the
// RN/SETN pulses, then reads Q back through a synchronizer to confirm the result.
module latrsnq_wr_ctrl
    import latrsnq_wr_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int WIDTH_CYC = WIDTH_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF,
    parameter int RECOV_CYC = RECOV_CYC_DEF
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic       req_data,
    output logic       lat_D,
    output logic       lat_E,
    output logic       lat_RN,
    output logic       lat_SETN,
    input  logic       lat_Q,
    output logic       done,
    output logic       err
);

    state_e     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    op_e        op_reg, op_next;
    logic       exp_reg, exp_next;
    logic       rsv_reg, rsv_next;
    logic       boot_reg, boot_next;
    logic       lat_d_reg, lat_d_next;
    logic       lat_e_reg, lat_e_next;
    logic       lat_rn_reg, lat_rn_next;
    logic       lat_setn_reg, lat_setn_next;
    logic       q_sync;

    latrsnq_wr_ctrl_sync u_sync (
        .CLK (CLK),
        .RN  (RN),
        .d   (lat_Q),
        .q   (q_sync)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_reg    <= INIT;
            cnt_reg      <= phase_load(WIDTH_CYC);
            op_reg       <= OP_WRITE;
            exp_reg      <= 1'b0;
            rsv_reg      <= 1'b0;
            boot_reg     <= 1'b1;
            lat_d_reg    <= 1'b0;
            lat_e_reg    <= 1'b0;
            lat_rn_reg   <= 1'b0;
            lat_setn_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            exp_reg      <= exp_next;
            rsv_reg      <= rsv_next;
            boot_reg     <= boot_next;
            lat_d_reg    <= lat_d_next;
            lat_e_reg    <= lat_e_next;
            lat_rn_reg   <= lat_rn_next;
            lat_setn_reg <= lat_setn_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg - 4'd1;
        op_next    = op_reg;
        exp_next   = exp_reg;
        rsv_next   = rsv_reg;
        boot_next  = boot_reg;
        lat_d_next = lat_d_reg;

        case (state_reg)
            INIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RECOV;
                    cnt_next   = phase_load(RECOV_CYC);
                end
            end
            IDLE: begin
                cnt_next = cnt_reg;
                if (req_valid) begin
                    op_next  = op_e'(req_op);
                    rsv_next = 1'b0;
                    case (op_e'(req_op))
                        OP_WRITE: begin
                            state_next = SETUP;
                            cnt_next   = phase_load(SETUP_CYC);
                            lat_d_next = req_data;
                            exp_next   = req_data;
                        end
                        OP_CLEAR: begin
                            state_next = ASYNC;
                            cnt_next   = phase_load(WIDTH_CYC);
                            exp_next   = 1'b0;
                        end
                        OP_PRESET: begin
                            state_next = ASYNC;
                            cnt_next   = phase_load(WIDTH_CYC);
                            exp_next   = 1'b1;
                        end
                        default: begin
                            // Reserved: single CHECK cycle that reports err without touching the latch.
                            state_next = CHECK;
                            cnt_next   = 4'd0;
                            rsv_next   = 1'b1;
                        end
                    endcase
                end
            end
            SETUP: begin
                if (cnt_reg == 4'd0) begin
                    state_next = PULSE;
                    cnt_next   = phase_load(WIDTH_CYC);
                end
            end
            PULSE: begin
                if (cnt_reg == 4'd0) begin
                    state_next = HOLD;
                    cnt_next   = phase_load(HOLD_CYC);
                end
            end
            HOLD: begin
                if (cnt_reg == 4'd0) begin
                    state_next = CHECK;
                    cnt_next   = phase_load(CHECK_CYC);
                end
            end
            ASYNC: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RECOV;
                    cnt_next   = phase_load(RECOV_CYC);
                end
            end
            RECOV: begin
                // The post-reset recovery skips the readback and never pulses done.
                if (cnt_reg == 4'd0) begin
                    if (boot_reg) begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                        boot_next  = 1'b0;
                    end else begin
                        state_next = CHECK;
                        cnt_next   = phase_load(CHECK_CYC);
                    end
                end
            end
            CHECK: begin
                if (cnt_reg == 4'd0) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = phase_load(WIDTH_CYC);
            end
        endcase
    end

    // Latch pins are registered from the next state so they change only on CLK edges.
    always_comb begin
        lat_e_next    = (state_next == PULSE);
        lat_rn_next   = !((state_next == INIT) ||
                          ((state_next == ASYNC) && (op_next == OP_CLEAR)));
        lat_setn_next = !((state_next == ASYNC) && (op_next == OP_PRESET));
    end

    assign lat_D     = lat_d_reg;
    assign lat_E     = lat_e_reg;
    assign lat_RN    = lat_rn_reg;
    assign lat_SETN  = lat_setn_reg;
    assign req_ready = (state_reg == IDLE);
    assign done      = (state_reg == CHECK) && (cnt_reg == 4'd0);
    assign err       = done && (rsv_reg || (q_sync != exp_reg));

endmodule

// File: tb/tb_latrsnq_wr_ctrl.sv
// Directed bench for latrsnq_wr_ctrl with a behavioural latch on the pins,
// followed by a random request stream checking latency, err and pin exclusivity.
module tb_latrsnq_wr_ctrl;

    logic       CLK = 1'b0;
    logic       RN;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic       req_data;
    logic       lat_D, lat_E, lat_RN, lat_SETN;
    logic       lat_Q;
    logic       done, err;

    logic latch_q = 1'b0;
    logic stuck0  = 1'b0;

    int vecs = 0;
    int errs = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int viol_cnt = 0;

    latrsnq_wr_ctrl dut (
        .CLK       (CLK),
        .RN        (RN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .lat_D     (lat_D),
        .lat_E     (lat_E),
        .lat_RN    (lat_RN),
        .lat_SETN  (lat_SETN),
        .lat_Q     (lat_Q),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Behavioural RN/SETN latch; stuck0 models a Q pin stuck low.
    always @(lat_RN or lat_SETN or lat_E or lat_D) begin
        if (!lat_RN)        latch_q = 1'b0;
        else if (!lat_SETN) latch_q = 1'b1;
        else if (lat_E)     latch_q = lat_D;
    end
    assign lat_Q = stuck0 ? 1'b0 : latch_q;

    always @(posedge CLK) begin
        if (req_valid && req_ready) hs_cnt++;
        if (done) done_cnt++;
        if (lat_E && (!lat_RN || !lat_SETN)) viol_cnt++;
        if (!lat_RN && !lat_SETN) viol_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vecs++;
        assert (got === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Pins {E,RN,SETN,D,ready,done,err} while RN is held low.
    task automatic check_reset_pins(input string tag);
        check(tag, {25'd0, lat_E, lat_RN, lat_SETN, lat_D, req_ready, done, err}, 32'b0010000);
    endtask

    // Release RN just after a rising edge; sample 0 is in the release cycle.
    task automatic boot_seq(input string tag);
        logic [11:0] rn_v, rdy_v, dn_v;
        rn_v = '0; rdy_v = '0; dn_v = '0;
        @(posedge CLK);
        #1 RN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            rn_v[c]  = lat_RN;
            rdy_v[c] = req_ready;
            dn_v[c]  = done;
        end
        check({tag, "_rn"},    {20'd0, rn_v},  32'h038);
        check({tag, "_ready"}, {20'd0, rdy_v}, 32'h020);
        check({tag, "_done"},  {20'd0, dn_v},  32'h000);
    endtask

    // One request; bit c of each vector is the pin value in cycle c (handshake at cycle 0).
    task automatic run_vec(input string tag, input logic [1:0] op, input logic data,
                           input logic [11:0] x_d, input logic [11:0] x_e,
                           input logic [11:0] x_rn, input logic [11:0] x_setn,
                           input logic [11:0] x_dn, input logic [11:0] x_er,
                           input logic [11:0] x_rdy);
        logic [11:0] d_v, e_v, rn_v, setn_v, dn_v, er_v, rdy_v;
        @(negedge CLK);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge CLK);
            d_v[c]    = lat_D;
            e_v[c]    = lat_E;
            rn_v[c]   = lat_RN;
            setn_v[c] = lat_SETN;
            dn_v[c]   = done;
            er_v[c]   = err;
            rdy_v[c]  = req_ready;
            if (c == 0) begin
                req_valid = 1'b1; req_op = op; req_data = data;
            end else if (c == 1) begin
                req_valid = 1'b0; req_op = 2'b00; req_data = 1'b0;
            end
        end
        check({tag, "_D"},     {20'd0, d_v},    {20'd0, x_d});
        check({tag, "_E"},     {20'd0, e_v},    {20'd0, x_e});
        check({tag, "_RN"},    {20'd0, rn_v},   {20'd0, x_rn});
        check({tag, "_SETN"},  {20'd0, setn_v}, {20'd0, x_setn});
        check({tag, "_done"},  {20'd0, dn_v},   {20'd0, x_dn});
        check({tag, "_err"},   {20'd0, er_v},   {20'd0, x_er});
        check({tag, "_ready"}, {20'd0, rdy_v},  {20'd0, x_rdy});
        $display("op %s: op=%0d data=%0d done_vec=%h err_vec=%h", tag, op, data, dn_v, er_v);
    endtask

    initial begin
        logic [1:0] r_op;
        logic       r_data;
        logic       any_done;
        logic       exp_err;
        int         t;
        int         lat;
        int         exp_lat;

        req_valid = 1'b0; req_op = 2'b00; req_data = 1'b0;
        RN = 1'b1;
        #1 RN = 1'b0;
        #1 check_reset_pins("reset_pins");
        repeat (2) @(posedge CLK);
        check_reset_pins("reset_hold");
        boot_seq("boot");

        //       tag          op     d     D        E        RN       SETN     done     err      ready
        run_vec("write1",   2'b00, 1'b1, 12'hFFE, 12'h038, 12'hFFF, 12'hFFF, 12'h200, 12'h000, 12'hC01);
        run_vec("clear",    2'b01, 1'b0, 12'hFFF, 12'h000, 12'hFF1, 12'hFFF, 12'h100, 12'h000, 12'hE01);
        run_vec("preset",   2'b10, 1'b0, 12'hFFF, 12'h000, 12'hFFF, 12'hFF1, 12'h100, 12'h000, 12'hE01);
        run_vec("write0",   2'b00, 1'b0, 12'h001, 12'h038, 12'hFFF, 12'hFFF, 12'h200, 12'h000, 12'hC01);
        stuck0 = 1'b1;
        run_vec("preset_s0",2'b10, 1'b0, 12'h000, 12'h000, 12'hFFF, 12'hFF1, 12'h100, 12'h100, 12'hE01);
        run_vec("write1_s0",2'b00, 1'b1, 12'hFFE, 12'h038, 12'hFFF, 12'hFFF, 12'h200, 12'h200, 12'hC01);
        stuck0 = 1'b0;
        run_vec("reserved", 2'b11, 1'b1, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'h002, 12'h002, 12'hFFD);

        // Abort a write with RN in the middle of its E pulse.
        @(negedge CLK);
        req_valid = 1'b1; req_op = 2'b00; req_data = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            if (c == 1) req_valid = 1'b0;
        end
        check("abort_pre_E", {31'd0, lat_E}, 32'd1);
        #1 RN = 1'b0;
        #1 check_reset_pins("abort_pins");
        any_done = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            any_done = any_done | done;
        end
        check("abort_no_done", {31'd0, any_done}, 32'd0);
        $display("op abort: write aborted at cycle 4");
        boot_seq("reboot");

        // Random stream.
        hs_cnt = 0; done_cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_data = 1'($urandom_range(0, 1));
            stuck0 = ($urandom_range(0, 3) == 0);
            t = 0;
            while (!req_ready && t < 50) begin
                @(negedge CLK);
                t++;
            end
            check("rnd_ready", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b1; req_op = r_op; req_data = r_data;
            @(negedge CLK);
            req_valid = 1'b0;
            lat = 1;
            while (!done && lat < 40) begin
                @(negedge CLK);
                lat++;
            end
            exp_lat = (r_op == 2'b00) ? 9 : ((r_op == 2'b11) ? 1 : 8);
            exp_err = (r_op == 2'b11) ||
                      (stuck0 && (((r_op == 2'b00) && r_data) || (r_op == 2'b10)));
            check("rnd_latency", lat, exp_lat);
            check("rnd_err", {31'd0, err}, {31'd0, exp_err});
            $display("rnd %0d: op=%0d data=%0d stuck0=%0d latency=%0d err=%0d",
                     n, r_op, r_data, stuck0, lat, err);
            @(negedge CLK);
        end
        stuck0 = 1'b0;
        check("rnd_done_vs_handshake", done_cnt, hs_cnt);
        check("pin_exclusivity", viol_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
